au_dispatch: RTL and testbench
==============================

AU_DISPATCH -- requirements
Module: au_dispatch

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, request queue entries (power of two, >=2).
REQ-002 Parameter: AU_LATENCY, 1, cycles from AU_op_enable pulse to AU_out sample (>=1).
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: req_valid  input  1  request present.
REQ-006 Port: req_ready  output  1  queue can accept request.
REQ-007 Port: req_mode  input  `OPCODE_WIDTH  opcode (`NOP/`ADD/`SUB/`MULT/`DIV).
REQ-008 Port: req_op_1, req_op_2  input  `DATA_WIDTH each  operands.
REQ-009 Port: rsp_valid  output  1  result present.
REQ-010 Port: rsp_ready  input  1  consumer accepts result.
REQ-011 Port: rsp_data  output  `DATA_WIDTH  result.
REQ-012 Port: rsp_err  output  1  result invalid (divide-by-zero or unknown opcode).
REQ-013 Port: AU_op_enable  output  1  AU trigger, registered.
REQ-014 Port: Mode  output  `OPCODE_WIDTH  opcode to AU, registered.
REQ-015 Port: AU_in_1, AU_in_2  output  `DATA_WIDTH each  operands to AU, registered.
REQ-016 Port: AU_out  input  `DATA_WIDTH  AU result.
REQ-017 Port: busy  output  1  high when FSM not IDLE or queue non-empty.

Function
REQ-018 Request handshake SHALL complete when req_valid && req_ready on a rising edge; req_ready = !full, no bypass when full (push rejected even if a pop occurs that cycle).
REQ-019 Queue SHALL be FIFO_DEPTH-deep, in-order, with wrap-around read/write pointers and a count; simultaneous push and pop SHALL keep count unchanged.
REQ-020 FSM states SHALL be IDLE, SETUP, FIRE, WAIT, DONE.
REQ-021 IDLE: if queue non-empty, pop head; `ADD/`SUB/`MULT, or `DIV with op_2!=0: register Mode/AU_in_1/AU_in_2 -> SETUP.
REQ-022 IDLE: popped `NOP SHALL be discarded: no AU pulse, no response, stay IDLE.
REQ-023 IDLE: popped `DIV with op_2==0, or any undefined opcode: no AU pulse; load rsp_data=0, rsp_err=1, rsp_valid=1 -> DONE.
REQ-024 SETUP: hold AU inputs one cycle with AU_op_enable=0 -> FIRE.
REQ-025 FIRE: AU_op_enable=1 for exactly one cycle, inputs held -> WAIT.
REQ-026 WAIT: AU_op_enable=0, inputs held, count AU_LATENCY cycles; at last WAIT cycle capture AU_out into rsp_data, rsp_err=0, rsp_valid=1 -> DONE.
REQ-027 DONE: hold rsp_valid/rsp_data/rsp_err stable until rsp_ready; on handshake clear rsp_valid -> IDLE.
REQ-028 Latency: request accepted at edge N into empty queue with FSM IDLE SHALL give AU_op_enable high in cycle N+3 and rsp_valid high from cycle N+4+AU_LATENCY.
REQ-029 At most one operation SHALL be in flight; queue keeps accepting while FSM is busy.
REQ-030 Mode/AU_in_* SHALL retain last issued values outside SETUP/FIRE/WAIT.
REQ-031 AU_op_enable SHALL return low for >=1 cycle between consecutive pulses.

Reset
REQ-032 rst SHALL, on the clock edge, empty the queue, put FSM in IDLE, zero AU_op_enable, Mode, AU_in_1, AU_in_2, rsp_valid, rsp_data, rsp_err, busy; req_ready=1 in the cycle after.
REQ-033 rst mid-operation (any state) SHALL abort the in-flight operation without a response; AU_out is ignored.
REQ-034 rst SHALL override a simultaneous request or response handshake; the request is dropped.

Verification
REQ-035 `ADD 3,2 with rsp_ready=1, AU_LATENCY=1 -> single AU_op_enable pulse at N+3, rsp_valid at N+5, rsp_data=5, rsp_err=0.
REQ-036 `DIV 7,0 -> no AU_op_enable pulse, rsp_data=0, rsp_err=1; then `SUB 9,4 -> rsp_data=5.
REQ-037 rsp_ready=0; push 5 requests back-to-back -> req_ready low after 4th entry until a pop; all 5 responses in order once rsp_ready=1.
REQ-038 `NOP then `MULT 6,7 -> one response only, rsp_data=42, one AU pulse.
REQ-039 rst asserted in WAIT with 2 queued entries -> all outputs 0, busy=0, no response; subsequent `ADD 1,1 -> rsp_data=2.
REQ-040 rsp_valid held with rsp_ready=0 for 10 cycles -> rsp_data/rsp_err stable, no AU pulse until accepted.

Source files
------------

// File: rtl/au_dispatch.sv
// rtl/au_dispatch.sv - request queue and single-issue dispatcher driving an external arithmetic unit
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 3
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef NOP
`define NOP  3'd0
`define ADD  3'd1
`define SUB  3'd2
`define MULT 3'd3
`define DIV  3'd4
`endif

module au_dispatch #(
    parameter int FIFO_DEPTH = 4,
    parameter int AU_LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [`OPCODE_WIDTH-1:0] req_mode,
    input  logic [`DATA_WIDTH-1:0]   req_op_1,
    input  logic [`DATA_WIDTH-1:0]   req_op_2,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [`DATA_WIDTH-1:0]   rsp_data,
    output logic                     rsp_err,
    output logic                     AU_op_enable,
    output logic [`OPCODE_WIDTH-1:0] Mode,
    output logic [`DATA_WIDTH-1:0]   AU_in_1,
    output logic [`DATA_WIDTH-1:0]   AU_in_2,
    input  logic [`DATA_WIDTH-1:0]   AU_out,
    output logic                     busy
);

    localparam int OW  = `OPCODE_WIDTH;
    localparam int DW  = `DATA_WIDTH;
    localparam int EW  = OW + 2 * DW;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;
    localparam int WCW = $clog2(AU_LATENCY + 1);

    typedef enum logic [2:0] {IDLE, SETUP, FIRE, WAIT, DONE} state_t;

    state_t         state, state_next;
    logic [EW-1:0]  mem [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic [WCW-1:0] wait_cnt;
    logic           full, empty, push, pop;
    logic           load_au, load_err, capture;
    logic [EW-1:0]  head;
    logic [OW-1:0]  head_mode;
    logic [DW-1:0]  head_op_1, head_op_2;

    assign full      = (count == CW'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign req_ready = !full;
    assign push      = req_valid && !full;
    assign busy      = (state != IDLE) || !empty;

    assign head      = mem[rd_ptr];
    assign head_mode = head[EW-1 -: OW];
    assign head_op_1 = head[2*DW-1 -: DW];
    assign head_op_2 = head[DW-1:0];

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        load_au    = 1'b0;
        load_err   = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    case (head_mode)
                        `NOP: ;
                        `ADD, `SUB, `MULT: begin
                            load_au    = 1'b1;
                            state_next = SETUP;
                        end
                        `DIV: begin
                            if (head_op_2 != '0) begin
                                load_au    = 1'b1;
                                state_next = SETUP;
                            end else begin
                                load_err   = 1'b1;
                                state_next = DONE;
                            end
                        end
                        default: begin
                            load_err   = 1'b1;
                            state_next = DONE;
                        end
                    endcase
                end
            end
            SETUP: state_next = FIRE;
            FIRE:  state_next = WAIT;
            WAIT: begin
                if (wait_cnt == WCW'(AU_LATENCY - 1)) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Queue storage carries no reset; only the pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {req_mode, req_op_1, req_op_2};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            wait_cnt     <= '0;
            AU_op_enable <= 1'b0;
            Mode         <= '0;
            AU_in_1      <= '0;
            AU_in_2      <= '0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            rsp_err      <= 1'b0;
        end else begin
            state <= state_next;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            wait_cnt     <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
            AU_op_enable <= (state_next == FIRE);
            if (load_au) begin
                Mode    <= head_mode;
                AU_in_1 <= head_op_1;
                AU_in_2 <= head_op_2;
            end
            if (capture) begin
                rsp_data  <= AU_out;
                rsp_err   <= 1'b0;
                rsp_valid <= 1'b1;
            end else if (load_err) begin
                rsp_data  <= '0;
                rsp_err   <= 1'b1;
                rsp_valid <= 1'b1;
            end else if (state == DONE && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_au_dispatch.sv
// tb/tb_au_dispatch.sv - directed self-checking bench for au_dispatch
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 3
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef NOP
`define NOP  3'd0
`define ADD  3'd1
`define SUB  3'd2
`define MULT 3'd3
`define DIV  3'd4
`endif

module tb_au_dispatch;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [2:0]  req_mode;
    logic [31:0] req_op_1, req_op_2;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        AU_op_enable;
    logic [2:0]  Mode;
    logic [31:0] AU_in_1, AU_in_2, AU_out;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    au_dispatch #(.FIFO_DEPTH(4), .AU_LATENCY(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_op_1(req_op_1), .req_op_2(req_op_2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .AU_op_enable(AU_op_enable), .Mode(Mode), .AU_in_1(AU_in_1), .AU_in_2(AU_in_2),
        .AU_out(AU_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // External arithmetic unit: combinational, held inputs satisfy a one-cycle latency.
    always_comb begin
        case (Mode)
            `ADD:    AU_out = AU_in_1 + AU_in_2;
            `SUB:    AU_out = AU_in_1 - AU_in_2;
            `MULT:   AU_out = AU_in_1 * AU_in_2;
            `DIV:    AU_out = (AU_in_2 != 0) ? AU_in_1 / AU_in_2 : 32'd0;
            default: AU_out = 32'd0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge with req_valid still high.
    task automatic push(input logic [2:0] m, input logic [31:0] a, input logic [31:0] b);
        int w;
        req_mode = m; req_op_1 = a; req_op_2 = b; req_valid = 1'b1;
        w = 0;
        while (!req_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) check("push_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_op(input string tag, input logic [2:0] m, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ed, input logic ee,
                         output int pk, output int rk);
        int  pulses;
        bit  got;
        pk = 0; rk = 0; pulses = 0; got = 0;
        rsp_ready = 1'b1;
        push(m, a, b);
        req_valid = 1'b0;
        for (int k = 1; k <= 40 && !got; k++) begin
            if (AU_op_enable) begin
                pulses++;
                if (pk == 0) pk = k;
            end
            if (rsp_valid) begin
                got = 1;
                rk  = k;
                check({tag, "_data"}, rsp_data, ed);
                check({tag, "_err"}, {31'd0, rsp_err}, {31'd0, ee});
            end
            @(negedge clk);
        end
        check({tag, "_got_rsp"}, {31'd0, got}, 32'd1);
        check({tag, "_pulses"}, pulses, ee ? 32'd0 : 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int pk, rk, n, changed, pulses, ready_hi, resp;
        logic [31:0] got_data [5];
        logic [31:0] exp_data [5];

        rst = 1'b1; req_valid = 1'b0; req_mode = '0; req_op_1 = '0; req_op_2 = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_au_en", {31'd0, AU_op_enable}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // ADD 3,2: pulse in third cycle after acceptance, response in fifth
        do_op("add", `ADD, 32'd3, 32'd2, 32'd5, 1'b0, pk, rk);
        check("add_pulse_cycle", pk, 32'd3);
        check("add_rsp_cycle", rk, 32'd5);

        do_op("div0", `DIV, 32'd7, 32'd0, 32'd0, 1'b1, pk, rk);
        do_op("sub", `SUB, 32'd9, 32'd4, 32'd5, 1'b0, pk, rk);
        do_op("badop", 3'd7, 32'd1, 32'd2, 32'd0, 1'b1, pk, rk);
        do_op("div", `DIV, 32'd21, 32'd4, 32'd5, 1'b0, pk, rk);

        // NOP is discarded, MULT yields the only response
        rsp_ready = 1'b1;
        push(`NOP, 32'd1, 32'd1);
        push(`MULT, 32'd6, 32'd7);
        req_valid = 1'b0;
        resp = 0; pulses = 0; got_data[0] = '0;
        for (int k = 0; k < 30; k++) begin
            if (AU_op_enable) pulses++;
            if (rsp_valid) begin
                if (resp == 0) got_data[0] = rsp_data;
                resp++;
            end
            @(negedge clk);
        end
        check("nop_mult_rsp_count", resp, 32'd1);
        check("nop_mult_data", got_data[0], 32'd42);
        check("nop_mult_pulses", pulses, 32'd1);

        // Back-pressure: five requests with the consumer stalled
        rsp_ready = 1'b0;
        push(`ADD, 32'd10, 32'd1);
        push(`SUB, 32'd10, 32'd3);
        push(`MULT, 32'd3, 32'd4);
        push(`DIV, 32'd20, 32'd5);
        push(`ADD, 32'd100, 32'd200);
        req_valid = 1'b0;
        check("full_req_ready", {31'd0, req_ready}, 32'd0);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        changed = 0; pulses = 0; ready_hi = 0;
        for (int k = 0; k < 10; k++) begin
            if (rsp_data !== 32'd11 || rsp_err !== 1'b0 || rsp_valid !== 1'b1) changed++;
            if (AU_op_enable) pulses++;
            if (req_ready) ready_hi++;
            @(negedge clk);
        end
        check("hold_stable", changed, 32'd0);
        check("hold_no_pulse", pulses, 32'd0);
        check("hold_ready_low", ready_hi, 32'd0);

        exp_data[0] = 32'd11; exp_data[1] = 32'd7; exp_data[2] = 32'd12;
        exp_data[3] = 32'd4;  exp_data[4] = 32'd300;
        rsp_ready = 1'b1;
        resp = 0;
        for (int k = 0; k < 200 && resp < 5; k++) begin
            if (rsp_valid) begin
                got_data[resp] = rsp_data;
                resp++;
            end
            @(negedge clk);
        end
        check("order_count", resp, 32'd5);
        for (int i = 0; i < resp; i++) check($sformatf("order_%0d", i), got_data[i], exp_data[i]);

        // Reset while the AU is in WAIT with two entries queued
        push(`ADD, 32'd5, 32'd5);
        push(`SUB, 32'd8, 32'd1);
        push(`ADD, 32'd2, 32'd2);
        req_valid = 1'b0;
        n = 0;
        while (!AU_op_enable && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("mid_pulse_seen", {31'd0, AU_op_enable}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_outputs", {rsp_valid, rsp_err, AU_op_enable, busy, |Mode, |AU_in_1, |AU_in_2, |rsp_data}, 32'd0);
        check("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
        rst = 1'b0;
        resp = 0; pulses = 0;
        for (int k = 0; k < 15; k++) begin
            if (rsp_valid) resp++;
            if (AU_op_enable) pulses++;
            @(negedge clk);
        end
        check("mid_rst_no_rsp", resp, 32'd0);
        check("mid_rst_no_pulse", pulses, 32'd0);
        do_op("post_rst_add", `ADD, 32'd1, 32'd1, 32'd2, 1'b0, pk, rk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
